// File: rtl/colddrink_dispenser.sv
// colddrink_dispenser: vending controller for coke (3), pepsi (4) and maaza (2) with change and refund.
//   clock          rising-edge system clock
//   reset          synchronous active-low reset
//   input_coin     coin value 1..7, 0 = no coin
//   sel_colddrink  00 none/cancel, 01 coke, 10 pepsi, 11 maaza
//   out            one-cycle dispense strobe
//   coke/pepsi/maaza  one-cycle drink strobes, asserted together with out
//   change         change or refund amount, nonzero only in the dispense/refund cycle
//   balance        accumulated credit
module colddrink_dispenser (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] input_coin,
    input  logic [1:0] sel_colddrink,
    output logic       out,
    output logic       coke,
    output logic       pepsi,
    output logic       maaza,
    output logic [2:0] change,
    output logic [2:0] balance
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] REFUND   = 2'd3;

    logic [1:0] state, state_n, drink, drink_n, cur_sel;
    logic [2:0] prev_coin, cur_price, change_n, balance_n;
    logic [3:0] sum, diff;
    logic       coin_ok, out_n, coke_n, pepsi_n, maaza_n;

    function automatic logic [2:0] price_of(input logic [1:0] s);
        return s == 2'b01 ? 3'd3 : s == 2'b10 ? 3'd4 : 3'd2;
    endfunction

    // A coin counts only on the cycle its value first appears, so a held coin is taken once.
    assign coin_ok   = input_coin != 3'd0 && input_coin != prev_coin;
    // With no credit yet the selection still follows the panel; credit locks it.
    assign cur_sel   = balance == 3'd0 ? sel_colddrink : drink;
    assign cur_price = price_of(cur_sel);
    assign sum       = {1'b0, balance} + {1'b0, input_coin};
    assign diff      = sum - {1'b0, cur_price};

    always_comb begin
        state_n   = state;
        drink_n   = drink;
        balance_n = balance;
        change_n  = 3'd0;
        out_n     = 1'b0;
        coke_n    = 1'b0;
        pepsi_n   = 1'b0;
        maaza_n   = 1'b0;
        case (state)
            IDLE: begin
                balance_n = 3'd0;
                if (sel_colddrink != 2'b00) begin
                    state_n = COLLECT;
                    drink_n = sel_colddrink;
                end
            end
            COLLECT: begin
                if (sel_colddrink == 2'b00) begin
                    // Cancel wins over a coin arriving in the same cycle.
                    state_n   = balance == 3'd0 ? IDLE : REFUND;
                    change_n  = balance;
                    balance_n = 3'd0;
                end else begin
                    drink_n = cur_sel;
                    if (coin_ok) begin
                        if (sum >= {1'b0, cur_price}) begin
                            state_n   = DISPENSE;
                            out_n     = 1'b1;
                            coke_n    = cur_sel == 2'b01;
                            pepsi_n   = cur_sel == 2'b10;
                            maaza_n   = cur_sel == 2'b11;
                            change_n  = diff[2:0];
                            balance_n = 3'd0;
                        end else begin
                            balance_n = sum[2:0];
                        end
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                balance_n = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            drink     <= 2'b00;
            prev_coin <= 3'd0;
            balance   <= 3'd0;
            change    <= 3'd0;
            out       <= 1'b0;
            coke      <= 1'b0;
            pepsi     <= 1'b0;
            maaza     <= 1'b0;
        end else begin
            state     <= state_n;
            drink     <= drink_n;
            prev_coin <= input_coin;
            balance   <= balance_n;
            change    <= change_n;
            out       <= out_n;
            coke      <= coke_n;
            pepsi     <= pepsi_n;
            maaza     <= maaza_n;
        end
    end
endmodule

// File: tb/tb_colddrink_dispenser.sv
// tb_colddrink_dispenser: scenario tasks with a queue of expected per-cycle outputs for colddrink_dispenser.
module tb_colddrink_dispenser;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] input_coin = 3'd0;
    logic [1:0] sel_colddrink = 2'b00;
    logic       out, coke, pepsi, maaza;
    logic [2:0] change, balance;
    logic [9:0] got, exp_v;
    logic [9:0] sb[$];
    int         vectors = 0;
    int         errors = 0;

    typedef struct packed {
        logic       rst;
        logic [1:0] sel;
        logic [2:0] coin;
        logic [9:0] e;
    } vec_t;

    colddrink_dispenser dut (
        .clock(clock), .reset(reset), .input_coin(input_coin), .sel_colddrink(sel_colddrink),
        .out(out), .coke(coke), .pepsi(pepsi), .maaza(maaza), .change(change), .balance(balance)
    );

    always #5 clock = ~clock;
    assign got = {out, coke, pepsi, maaza, change, balance};

    function automatic logic [9:0] ev(input logic o, k, p, m, input logic [2:0] ch, b);
        return {o, k, p, m, ch, b};
    endfunction

    function automatic vec_t v(input logic r, input logic [1:0] s, input logic [2:0] c, input logic [9:0] e);
        return {r, s, c, e};
    endfunction

    task automatic test_reset();
        vec_t t[2];
        t = '{v(0, 2'b01, 3'd3, ev(0,0,0,0,0,0)), v(0, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL reset[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_coke();
        vec_t t[4];
        t = '{v(1, 2'b01, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b01, 3'd1, ev(0,0,0,0,0,1)),
              v(1, 2'b01, 3'd2, ev(1,1,0,0,0,0)), v(1, 2'b01, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL coke[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_pepsi_held_coin();
        vec_t t[6];
        t = '{v(1, 2'b10, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b10, 3'd5, ev(1,0,1,0,1,0)),
              v(1, 2'b10, 3'd5, ev(0,0,0,0,0,0)), v(1, 2'b10, 3'd5, ev(0,0,0,0,0,0)),
              v(1, 2'b10, 3'd5, ev(0,0,0,0,0,0)), v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL pepsi_held[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_maaza();
        vec_t t[7];
        t = '{v(1, 2'b11, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b11, 3'd2, ev(1,0,0,1,0,0)),
              v(1, 2'b11, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b11, 3'd0, ev(0,0,0,0,0,0)),
              v(1, 2'b11, 3'd5, ev(1,0,0,1,3,0)), v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL maaza[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_refund();
        vec_t t[8];
        t = '{v(1, 2'b01, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b01, 3'd2, ev(0,0,0,0,0,2)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,2,0)), v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0)),
              v(1, 2'b01, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b01, 3'd1, ev(0,0,0,0,0,1)),
              v(1, 2'b00, 3'd2, ev(0,0,0,0,1,0)), v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL refund[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_reselect_and_max_change();
        vec_t t[9];
        t = '{v(1, 2'b01, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b10, 3'd0, ev(0,0,0,0,0,0)),
              v(1, 2'b10, 3'd3, ev(0,0,0,0,0,3)), v(1, 2'b10, 3'd1, ev(1,0,1,0,0,0)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b10, 3'd0, ev(0,0,0,0,0,0)),
              v(1, 2'b10, 3'd3, ev(0,0,0,0,0,3)), v(1, 2'b01, 3'd7, ev(1,0,1,0,6,0)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL reselect[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_same_coin_reentry();
        vec_t t[7];
        t = '{v(1, 2'b10, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b10, 3'd2, ev(0,0,0,0,0,2)),
              v(1, 2'b10, 3'd0, ev(0,0,0,0,0,2)), v(1, 2'b10, 3'd2, ev(1,0,1,0,0,0)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b00, 3'd3, ev(0,0,0,0,0,0)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL same_coin[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    task automatic test_reset_mid_purchase();
        vec_t t[8];
        t = '{v(1, 2'b01, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b01, 3'd2, ev(0,0,0,0,0,2)),
              v(0, 2'b01, 3'd0, ev(0,0,0,0,0,0)), v(1, 2'b01, 3'd2, ev(0,0,0,0,0,0)),
              v(1, 2'b01, 3'd2, ev(0,0,0,0,0,0)), v(1, 2'b01, 3'd1, ev(0,0,0,0,0,1)),
              v(1, 2'b00, 3'd0, ev(0,0,0,0,1,0)), v(1, 2'b00, 3'd0, ev(0,0,0,0,0,0))};
        foreach (t[i]) begin
            reset = t[i].rst; sel_colddrink = t[i].sel; input_coin = t[i].coin;
            sb.push_back(t[i].e);
            @(posedge clock); #1;
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin errors++; $display("FAIL reset_mid[%0d]: got o,k,p,m,chg,bal=%b expected %b", i, got, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_coke();
        test_pepsi_held_coin();
        test_maaza();
        test_refund();
        test_reselect_and_max_change();
        test_same_coin_reentry();
        test_reset_mid_purchase();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
